// File: rtl/miriscv_trace_pkg.sv
// rtl/miriscv_trace_pkg.sv - record type, field widths and channel-count helpers for the RVFI trace buffer
package miriscv_trace_pkg;

  localparam int ORDER_W = 64;
  localparam int XLEN    = 32;
  localparam int INSN_W  = 32;
  localparam int REG_AW  = 5;
  localparam int MASK_W  = 4;
  localparam int MAX_NRET = 4;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [INSN_W-1:0]  insn;
    logic               trap;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [REG_AW-1:0]  rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic [XLEN-1:0]    mem_addr;
    logic [MASK_W-1:0]  mem_rmask;
    logic [MASK_W-1:0]  mem_wmask;
    logic [XLEN-1:0]    mem_rdata;
    logic [XLEN-1:0]    mem_wdata;
  } trace_rec_t;

  // Number of set bits of v strictly below index k; k = MAX_NRET gives the full popcount.
  function automatic logic [2:0] rank4(input logic [MAX_NRET-1:0] v, input int k);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_NRET; i++) begin
      if (i < k && v[i]) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/miriscv_rvfi_trace_buffer_if.sv
// rtl/miriscv_rvfi_trace_buffer_if.sv - valid/ready trace record stream
interface miriscv_rvfi_trace_buffer_if;
  import miriscv_trace_pkg::*;

  logic       trace_valid;
  logic       trace_ready;
  trace_rec_t trace_rec;

  modport master (output trace_valid, output trace_rec, input trace_ready);
  modport slave  (input trace_valid, input trace_rec, output trace_ready);

endinterface

// File: rtl/miriscv_trace_fifo.sv
// rtl/miriscv_trace_fifo.sv - multi-write, single-read FIFO of trace records
module miriscv_trace_fifo
  import miriscv_trace_pkg::*;
#(
  parameter int NRET  = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [$clog2(NRET+1)-1:0]  wr_cnt_i,
  input  trace_rec_t [NRET-1:0]      wr_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       head_valid_o,
  output trace_rec_t                 head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  trace_rec_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok;

  assign pop_ok = pop_i && (level_q != '0);

  // Pointer/level next state; the caller guarantees wr_cnt_i fits the free space.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(wr_cnt_i);
    rptr_d  = rptr_q + PTR_W'(pop_ok);
    level_d = level_q + LVL_W'(wr_cnt_i) - LVL_W'(pop_ok);
  end

  // Pointer/level registers; flush empties the FIFO like reset but keeps contents.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage: slot j of the compacted write bundle lands at wptr + j.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int j = 0; j < NRET; j++) begin
        if (j < int'(wr_cnt_i)) mem_q[wptr_q + PTR_W'(j)] <= wr_data_i[j];
      end
    end
  end

  assign level_o      = level_q;
  assign head_valid_o = (level_q != '0);
  assign head_o       = head_valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/miriscv_rvfi_trace_buffer.sv
// rtl/miriscv_rvfi_trace_buffer.sv - RVFI retirement capture with order stamping and drop counting
module miriscv_rvfi_trace_buffer
  import miriscv_trace_pkg::*;
#(
  parameter int NRET   = 1,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        trace_en_i,
  input  logic                        flush_i,
  input  logic [NRET-1:0]             rvfi_valid_i,
  input  logic [NRET*INSN_W-1:0]      rvfi_insn_i,
  input  logic [NRET-1:0]             rvfi_trap_i,
  input  logic [NRET*XLEN-1:0]        rvfi_pc_rdata_i,
  input  logic [NRET*XLEN-1:0]        rvfi_pc_wdata_i,
  input  logic [NRET*REG_AW-1:0]      rvfi_rd_addr_i,
  input  logic [NRET*XLEN-1:0]        rvfi_rd_wdata_i,
  input  logic [NRET*XLEN-1:0]        rvfi_mem_addr_i,
  input  logic [NRET*MASK_W-1:0]      rvfi_mem_rmask_i,
  input  logic [NRET*MASK_W-1:0]      rvfi_mem_wmask_i,
  input  logic [NRET*XLEN-1:0]        rvfi_mem_rdata_i,
  input  logic [NRET*XLEN-1:0]        rvfi_mem_wdata_i,
  miriscv_rvfi_trace_buffer_if.master trace_if,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  output logic [DROP_W-1:0]           drop_cnt_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(NRET + 1);
  localparam int SUM_W = DROP_W + 1;

  logic [NRET-1:0]    eff_valid;
  logic [CNT_W-1:0]   n;
  logic [LVL_W-1:0]   free;
  logic               accept, drop;
  logic [CNT_W-1:0]   wr_cnt;
  trace_rec_t [NRET-1:0] wr_data;
  logic [SUM_W-1:0]   drop_sum;
  logic [ORDER_W-1:0] order_cnt_q, order_cnt_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               overflow_q, overflow_d;
  logic               head_valid;
  trace_rec_t         head;

  assign eff_valid = rvfi_valid_i & {NRET{trace_en_i}};
  assign n         = CNT_W'(rank4(MAX_NRET'(eff_valid), MAX_NRET));

  // Admission is judged against pre-pop free space; flush discards the cycle's records outright.
  assign free     = LVL_W'(DEPTH) - level_o;
  assign accept   = !flush_i && (LVL_W'(n) <= free);
  assign drop     = !flush_i && !accept;
  assign wr_cnt   = accept ? n : '0;
  assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(n);

  // Compact valid channels into consecutive write slots, stamping order by rank.
  always_comb begin
    logic [2:0] r;
    wr_data = '0;
    r       = '0;
    for (int k = 0; k < NRET; k++) begin
      r = rank4(MAX_NRET'(eff_valid), k);
      for (int j = 0; j < NRET; j++) begin
        if (eff_valid[k] && (r == 3'(j))) begin
          wr_data[j].order     = order_cnt_q + ORDER_W'(r);
          wr_data[j].insn      = rvfi_insn_i[k*INSN_W +: INSN_W];
          wr_data[j].trap      = rvfi_trap_i[k];
          wr_data[j].pc_rdata  = rvfi_pc_rdata_i[k*XLEN +: XLEN];
          wr_data[j].pc_wdata  = rvfi_pc_wdata_i[k*XLEN +: XLEN];
          wr_data[j].rd_addr   = rvfi_rd_addr_i[k*REG_AW +: REG_AW];
          wr_data[j].rd_wdata  = rvfi_rd_wdata_i[k*XLEN +: XLEN];
          wr_data[j].mem_addr  = rvfi_mem_addr_i[k*XLEN +: XLEN];
          wr_data[j].mem_rmask = rvfi_mem_rmask_i[k*MASK_W +: MASK_W];
          wr_data[j].mem_wmask = rvfi_mem_wmask_i[k*MASK_W +: MASK_W];
          wr_data[j].mem_rdata = rvfi_mem_rdata_i[k*XLEN +: XLEN];
          wr_data[j].mem_wdata = rvfi_mem_wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Order always advances by n so that drops and flushes show up as gaps.
  always_comb begin
    order_cnt_d = order_cnt_q + ORDER_W'(n);
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    if (drop) begin
      drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      overflow_d = 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      order_cnt_q <= order_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  miriscv_trace_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .wr_cnt_i     (wr_cnt),
    .wr_data_i    (wr_data),
    .pop_i        (trace_if.trace_ready),
    .level_o      (level_o),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign trace_if.trace_valid = head_valid;
  assign trace_if.trace_rec   = head;
  assign overflow_o           = overflow_q;
  assign drop_cnt_o           = drop_cnt_q;

endmodule

// File: tb/tb_miriscv_rvfi_trace_buffer.sv
// tb/tb_miriscv_rvfi_trace_buffer.sv - directed self-checking bench for the RVFI trace buffer
module tb_miriscv_rvfi_trace_buffer;
  import miriscv_trace_pkg::*;

  localparam int NRET   = 2;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, trace_en, flush;
  logic [NRET-1:0]        rvfi_valid, rvfi_trap;
  logic [NRET*32-1:0]     rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [NRET*32-1:0]     rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [NRET*5-1:0]      rvfi_rd_addr;
  logic [NRET*4-1:0]      rvfi_mem_rmask, rvfi_mem_wmask;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [DROP_W-1:0]      drop_cnt;

  miriscv_rvfi_trace_buffer_if tif ();

  miriscv_rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .trace_en_i       (trace_en),
    .flush_i          (flush),
    .rvfi_valid_i     (rvfi_valid),
    .rvfi_insn_i      (rvfi_insn),
    .rvfi_trap_i      (rvfi_trap),
    .rvfi_pc_rdata_i  (rvfi_pc_rdata),
    .rvfi_pc_wdata_i  (rvfi_pc_wdata),
    .rvfi_rd_addr_i   (rvfi_rd_addr),
    .rvfi_rd_wdata_i  (rvfi_rd_wdata),
    .rvfi_mem_addr_i  (rvfi_mem_addr),
    .rvfi_mem_rmask_i (rvfi_mem_rmask),
    .rvfi_mem_wmask_i (rvfi_mem_wmask),
    .rvfi_mem_rdata_i (rvfi_mem_rdata),
    .rvfi_mem_wdata_i (rvfi_mem_wdata),
    .trace_if         (tif),
    .level_o          (level),
    .overflow_o       (overflow),
    .drop_cnt_o       (drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] insn);
    rvfi_valid[k]             = 1'b1;
    rvfi_insn[k*32 +: 32]     = insn;
    rvfi_pc_rdata[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    rvfi_rd_addr[k*5 +: 5]    = 5'(k + 1);
  endtask

  task automatic clr();
    rvfi_valid = '0;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] order, input logic [31:0] insn);
    chk({tag, "_valid"}, 64'(tif.trace_valid), 64'd1);
    chk({tag, "_order"}, tif.trace_rec.order, order);
    chk({tag, "_insn"}, 64'(tif.trace_rec.insn), 64'(insn));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_ord [6];
    rst = 1'b1; trace_en = 1'b1; flush = 1'b0; tif.trace_ready = 1'b0;
    rvfi_valid = '0; rvfi_trap = '0; rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_mem_addr = '0; rvfi_mem_rdata = '0;
    rvfi_mem_wdata = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 64'(tif.trace_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_rec", 64'(|tif.trace_rec), 64'd0);

    // Channel 1 only: one record, order 0, visible next cycle.
    set_ch(1, 32'h0050_0093); tick(); clr();
    chk_head("ch1", 64'd0, 32'h0050_0093);
    chk("ch1_pc", 64'(tif.trace_rec.pc_rdata), 64'h1000_0001);
    chk("ch1_rd", 64'(tif.trace_rec.rd_addr), 64'd2);
    chk("ch1_level", 64'(level), 64'd1);

    // Both channels: ch0 gets order 1, ch1 order 2; head stable while not ready.
    set_ch(0, 32'hA000_0000); set_ch(1, 32'hA000_0001); tick(); clr();
    chk("both_level", 64'(level), 64'd3);
    chk_head("hold", 64'd0, 32'h0050_0093);
    tif.trace_ready = 1'b1;
    tick(); chk_head("both0", 64'd1, 32'hA000_0000);
    chk("both0_pc", 64'(tif.trace_rec.pc_rdata), 64'h1000_0000);
    tick(); chk_head("both1", 64'd2, 32'hA000_0001);
    tick();
    chk("drain_valid", 64'(tif.trace_valid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);
    tick();
    chk("emptypop_level", 64'(level), 64'd0);
    tif.trace_ready = 1'b0;

    // Fill to DEPTH from a fresh reset, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_ch(0, 32'hB000_0000 + 32'(i)); tick();
    end
    clr();
    chk("full_level", 64'(level), 64'd8);
    chk("full_drop", 64'(drop_cnt), 64'd0);
    set_ch(0, 32'hBBBB_0008); tick(); clr();
    chk("ovf_drop", 64'(drop_cnt), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd8);
    chk_head("ovf_head", 64'd0, 32'hB000_0000);

    // Pop one, then the next accepted record carries order 9.
    tif.trace_ready = 1'b1; tick(); tif.trace_ready = 1'b0;
    chk("pop1_level", 64'(level), 64'd7);
    set_ch(0, 32'hC000_0009); tick(); clr();
    chk("refill_level", 64'(level), 64'd8);

    // Full with a pop and a push in the same cycle: push dropped, pop happens.
    tif.trace_ready = 1'b1; set_ch(0, 32'hDEAD_000A); tick(); clr(); tif.trace_ready = 1'b0;
    chk("prepop_level", 64'(level), 64'd7);
    chk("prepop_drop", 64'(drop_cnt), 64'd2);

    // Level 7, two records offered: both dropped.
    set_ch(0, 32'hDEAD_000B); set_ch(1, 32'hDEAD_000C); tick(); clr();
    chk("aon_level", 64'(level), 64'd7);
    chk("aon_drop", 64'(drop_cnt), 64'd4);
    chk_head("aon_head", 64'd2, 32'hB000_0002);

    exp_ord = '{64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd9};
    tif.trace_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("drain_order", tif.trace_rec.order, exp_ord[i]);
    end
    chk("drain9_insn", 64'(tif.trace_rec.insn), 64'hC000_0009);
    tick();
    chk("drain_empty", 64'(tif.trace_valid), 64'd0);

    // Streaming one per cycle across pointer wrap; orders continue from 13.
    for (int i = 0; i < 24; i++) begin
      set_ch(0, 32'hE000_0000 + 32'(i)); tick();
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_order", tif.trace_rec.order, 64'd13 + 64'(i));
    end
    clr(); tick();
    chk("stream_end_level", 64'(level), 64'd0);
    chk("stream_drop", 64'(drop_cnt), 64'd4);
    tif.trace_ready = 1'b0;

    // Flush at level 5 with a simultaneous two-record push (orders 42, 43 consumed).
    for (int i = 0; i < 5; i++) begin
      set_ch(0, 32'hF000_0000 + 32'(i)); tick();
    end
    clr();
    chk("preflush_level", 64'(level), 64'd5);
    flush = 1'b1; set_ch(0, 32'hF0F0_0000); set_ch(1, 32'hF0F0_0001); tick();
    flush = 1'b0; clr();
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(tif.trace_valid), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd4);
    chk("flush_ovf", 64'(overflow), 64'd1);
    set_ch(0, 32'hF1F1_0000); tick(); clr();
    chk_head("postflush", 64'd44, 32'hF1F1_0000);

    // Reset mid-stream at level 3.
    set_ch(0, 32'h1111_0000); tick(); set_ch(0, 32'h1111_0001); tick(); clr();
    chk("prerst_level", 64'(level), 64'd3);
    do_reset();
    chk("mrst_valid", 64'(tif.trace_valid), 64'd0);
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    chk("mrst_drop", 64'(drop_cnt), 64'd0);
    chk("mrst_rec", 64'(|tif.trace_rec), 64'd0);

    // Capture disabled: nothing enqueued, order holds.
    trace_en = 1'b0; set_ch(0, 32'h2222_0000); tick(); clr(); trace_en = 1'b1;
    chk("dis_level", 64'(level), 64'd0);
    set_ch(1, 32'h3333_0001); tick(); clr();
    chk_head("post_rst", 64'd0, 32'h3333_0001);
    chk("post_rst_pc", 64'(tif.trace_rec.pc_rdata), 64'h1000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
